// File: rtl/prgrom_loader_if.sv
// Fetch/upgrade bus of the program ROM: fetch address and instruction on one side,
// UART byte stream and load status on the other.
interface prgrom_loader_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0] rom_adr_i;
   logic [31:0]       Jpadr;
   logic              upg_en;
   logic              upg_byte_valid;
   logic [7:0]        upg_byte;
   logic              cpu_hold;
   logic              upg_done;
   logic              upg_err;
   logic [ADDR_W:0]   upg_word_cnt;

   modport master (
      output rom_adr_i, upg_en, upg_byte_valid, upg_byte,
      input  Jpadr, cpu_hold, upg_done, upg_err, upg_word_cnt
   );

   modport slave (
      input  rom_adr_i, upg_en, upg_byte_valid, upg_byte,
      output Jpadr, cpu_hold, upg_done, upg_err, upg_word_cnt
   );
endinterface

// File: rtl/prgrom_loader.sv
// Program ROM for the Minisys-1A fetch path, refillable from a UART byte stream
// (N_hi, N_lo, N big-endian words, XOR checksum). Memory contents survive reset.
module prgrom_loader #(
   parameter int          ADDR_W           = 14,
   parameter logic [31:0] RESET_VECTOR_NOP = 32'h0000_0000
) (
   input logic             clock,
   input logic             reset,
   prgrom_loader_if.slave  bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR0  = 3'd1;
   localparam logic [2:0] S_HDR1  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CSUM  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   logic [31:0]     mem [0:(1<<ADDR_W)-1];
   logic [2:0]      state;
   logic [7:0]      n_hi;
   logic [7:0]      xor_acc;
   logic [1:0]      byte_idx;
   logic [31:0]     asm_word;
   logic [ADDR_W:0] n_words;
   logic [16:0]     n_full;
   logic [ADDR_W:0] cnt_next;
   logic            in_load;
   logic            abort;

   assign n_full   = {1'b0, n_hi, bus.upg_byte};
   assign cnt_next = bus.upg_word_cnt + 1'b1;
   assign in_load  = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA) ||
                     (state == S_WRITE) || (state == S_CSUM);
   assign abort    = in_load && !bus.upg_en;

   // Control: FSM, counters, status flags, registered CPU stall
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= S_IDLE;
         xor_acc          <= 8'h00;
         byte_idx         <= 2'd0;
         bus.upg_word_cnt <= '0;
         bus.upg_done     <= 1'b0;
         bus.upg_err      <= 1'b0;
         bus.cpu_hold     <= 1'b0;
      end else begin
         bus.cpu_hold <= bus.upg_en || (state != S_IDLE);
         if (abort) begin
            state       <= S_ERR;
            bus.upg_err <= 1'b1;
         end else begin
            case (state)
               S_IDLE: if (bus.upg_en) begin
                  state            <= S_HDR0;
                  xor_acc          <= 8'h00;
                  byte_idx         <= 2'd0;
                  bus.upg_word_cnt <= '0;
                  bus.upg_done     <= 1'b0;
                  bus.upg_err      <= 1'b0;
               end
               S_HDR0: if (bus.upg_byte_valid) state <= S_HDR1;
               S_HDR1: if (bus.upg_byte_valid) begin
                  if (n_full == 17'd0) begin
                     state <= S_CSUM;
                  end else if (n_full > MAX_WORDS) begin
                     state       <= S_ERR;
                     bus.upg_err <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: if (bus.upg_byte_valid) begin
                  xor_acc  <= xor_acc ^ bus.upg_byte;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) state <= S_WRITE;
               end
               S_WRITE: begin
                  bus.upg_word_cnt <= cnt_next;
                  byte_idx         <= 2'd0;
                  state            <= (cnt_next == n_words) ? S_CSUM : S_DATA;
               end
               S_CSUM: if (bus.upg_byte_valid) begin
                  if (bus.upg_byte == xor_acc) begin
                     state        <= S_DONE;
                     bus.upg_done <= 1'b1;
                  end else begin
                     state       <= S_ERR;
                     bus.upg_err <= 1'b1;
                  end
               end
               S_DONE, S_ERR: if (!bus.upg_en) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Data: header capture, word assembly and memory write (never reset)
   always_ff @(posedge clock) begin
      if (state == S_HDR0 && bus.upg_byte_valid) n_hi <= bus.upg_byte;
      if (state == S_HDR1 && bus.upg_byte_valid) n_words <= n_full[ADDR_W:0];
      if (state == S_DATA && bus.upg_byte_valid) asm_word <= {asm_word[23:0], bus.upg_byte};
      if (state == S_WRITE && !abort && !reset)
         mem[bus.upg_word_cnt[ADDR_W-1:0]] <= asm_word;
   end

   // Fetch port: one-cycle read, NOP while the CPU is held
   always_ff @(posedge clock) begin
      if (reset)             bus.Jpadr <= 32'h0000_0000;
      else if (bus.cpu_hold) bus.Jpadr <= RESET_VECTOR_NOP;
      else                   bus.Jpadr <= mem[bus.rom_adr_i];
   end
endmodule
